// File: rtl/div_sched.sv
// Runtime-programmable clock divider: divided waveform, period tick and ratio handshake.
// Optional `DIV_SCHED_SYNC_SWITCH_EN defers ratio changes to the period boundary.
module div_sched #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             div_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] cur_div_o
);

    localparam logic [CNT_W-1:0] DEF_DIV_C = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C     = CNT_W'(2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             div_q, div_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic             at_bnd_c;
    logic             accept_c;
    logic             bad_div_c;
    logic             ready_c;
    logic             run_d_c;

`ifdef DIV_SCHED_SYNC_SWITCH_EN
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             ready_q, ready_d;

    assign ready_c = ready_q;
`else
    assign ready_c = 1'b1;
`endif

    // Last cycle of the current period while the divider is active.
    assign at_bnd_c  = (state_q != S_IDLE) && (cnt_q == (cur_div_q - ONE_C));
    assign accept_c  = cfg_valid_i && ready_c;
    assign bad_div_c = (cfg_div_i < TWO_C);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        err_d     = 1'b0;
`ifdef DIV_SCHED_SYNC_SWITCH_EN
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = at_bnd_c ? '0 : (cnt_q + ONE_C);
                // A stop request on the boundary itself has no period left to finish.
                if (!en_i) begin
                    state_d = at_bnd_c ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = at_bnd_c ? '0 : (cnt_q + ONE_C);
                if (en_i) begin
                    state_d = S_RUN;
                end else if (at_bnd_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef DIV_SCHED_SYNC_SWITCH_EN
        if (at_bnd_c && pend_vld_q) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
        end
`endif

        // Ratio request; ready is low whenever a change is pending, so no overlap.
        if (accept_c) begin
            if (bad_div_c) begin
                err_d = 1'b1;
            end else if (state_q == S_IDLE) begin
                cur_div_d = cfg_div_i;
            end else begin
`ifdef DIV_SCHED_SYNC_SWITCH_EN
                if (at_bnd_c) begin
                    cur_div_d = cfg_div_i;
                end else begin
                    pend_div_d = cfg_div_i;
                    pend_vld_d = 1'b1;
                end
`else
                cur_div_d = cfg_div_i;
                cnt_d     = '0;
`endif
            end
        end

        // Outputs are registered, so they are derived from next-state values.
        run_d_c = (state_d != S_IDLE);
        busy_d  = run_d_c;
        tick_d  = run_d_c && (cnt_d == (cur_div_d - ONE_C));
        div_d   = run_d_c && (cnt_d >= (cur_div_d >> 1));
`ifdef DIV_SCHED_SYNC_SWITCH_EN
        ready_d = !pend_vld_d;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cur_div_q <= DEF_DIV_C;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DIV_SCHED_SYNC_SWITCH_EN
            pend_div_q <= DEF_DIV_C;
            pend_vld_q <= 1'b0;
            ready_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
`ifdef DIV_SCHED_SYNC_SWITCH_EN
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            ready_q    <= ready_d;
`endif
        end
    end

    assign cfg_ready_o = ready_c;
    assign cfg_err_o   = err_q;
    assign div_o       = div_q;
    assign tick_o      = tick_q;
    assign busy_o      = busy_q;
    assign cur_div_o   = cur_div_q;

endmodule
